// File: rtl/bert_pkg.sv
// bert_pkg: shared definitions for the bit-error-ratio engine.
//   - prbs_sel encodings and the order/tap pair of each polynomial
//   - checker FSM state enum
//   - popcount and hunt-fill helpers
package bert_pkg;

  localparam logic [1:0] SEL_PRBS7  = 2'b00;
  localparam logic [1:0] SEL_PRBS15 = 2'b01;
  localparam logic [1:0] SEL_PRBS23 = 2'b10;
  localparam logic [1:0] SEL_PRBS31 = 2'b11;

  // x^ORD + x^TAP + 1
  localparam int unsigned ORD7  = 7;
  localparam int unsigned TAP7  = 6;
  localparam int unsigned ORD15 = 15;
  localparam int unsigned TAP15 = 14;
  localparam int unsigned ORD23 = 23;
  localparam int unsigned TAP23 = 18;
  localparam int unsigned ORD31 = 31;
  localparam int unsigned TAP31 = 28;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  function automatic int unsigned poly_order(input logic [1:0] sel);
    case (sel)
      SEL_PRBS7:  return ORD7;
      SEL_PRBS15: return ORD15;
      SEL_PRBS23: return ORD23;
      default:    return ORD31;
    endcase
  endfunction

  // Words needed to fill the checker state with N received bits.
  function automatic logic [5:0] fill_words(input logic [1:0] sel, input int unsigned w);
    int unsigned n;
    n = poly_order(sel);
    return 6'((n + w - 1) / w);
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/bert_lfsr_step.sv
// bert_lfsr_step: combinational W-step advance of a 31-bit PRBS state.
//   state_i / state_o : current / advanced state, bit 0 = most recent bit
//   sel_i             : polynomial select
//   use_ext_i         : shift ext_i bits into the state instead of feedback
//   ext_i             : external bits, bit W-1 first in time
//   bits_o            : predicted (feedback) bits, bit W-1 first in time
module bert_lfsr_step
  import bert_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [30:0]  state_i,
  input  logic [1:0]   sel_i,
  input  logic         use_ext_i,
  input  logic [W-1:0] ext_i,
  output logic [30:0]  state_o,
  output logic [W-1:0] bits_o
);

  always_comb begin : step
    logic [30:0] s;
    logic        fb;
    s      = state_i;
    fb     = 1'b0;
    bits_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      case (sel_i)
        SEL_PRBS7:  fb = s[ORD7-1]  ^ s[TAP7-1];
        SEL_PRBS15: fb = s[ORD15-1] ^ s[TAP15-1];
        SEL_PRBS23: fb = s[ORD23-1] ^ s[TAP23-1];
        default:    fb = s[ORD31-1] ^ s[TAP31-1];
      endcase
      bits_o[i] = fb;
      s = {s[29:0], (use_ext_i ? ext_i[i] : fb)};
    end
    state_o = s;
  end

endmodule

// File: rtl/bert_engine.sv
// bert_engine: PRBS generator plus self-synchronising PRBS checker.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   en                 : advance generator one word (tx_data valid next cycle)
//   prbs_sel           : polynomial select; a change reseeds and rehunts
//   inject             : flip bit 0 of the next generated word
//   clear              : zero counters and sat
//   rx_data, rx_valid  : received word (bit W-1 first) and its qualifier
//   tx_data            : generated word (bit W-1 first)
//   locked             : checker in LOCKED
//   error              : mismatch mask of the last locked word, else 0
//   total_error, count : saturating bit-error / compared-bit counters
//   sat                : sticky, a counter reached all-ones
module bert_engine
  import bert_pkg::*;
#(
  parameter int W        = 8,
  parameter int CNT_W    = 32,
  parameter int ERR_W    = 16,
  parameter int SYNC_LEN = 4,
  parameter int LOSS_THR = 4,
  parameter int LOSS_WIN = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       prbs_sel,
  input  logic             inject,
  input  logic             clear,
  input  logic [W-1:0]     rx_data,
  input  logic             rx_valid,
  output logic [W-1:0]     tx_data,
  output logic             locked,
  output logic [W-1:0]     error,
  output logic [ERR_W-1:0] total_error,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int RUN_W = $clog2(SYNC_LEN + 1);
  localparam int WIN_W = $clog2(LOSS_WIN + 1);
  localparam int BAD_W = $clog2(LOSS_THR + 1);

  function automatic logic [ERR_W-1:0] sat_add_err(input logic [ERR_W-1:0] a,
                                                   input logic [5:0] b);
    logic [ERR_W+5:0] s;
    s = (ERR_W+6)'(a) + (ERR_W+6)'(b);
    if (s > (ERR_W+6)'({ERR_W{1'b1}})) return '1;
    return s[ERR_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [5:0] b);
    logic [CNT_W+5:0] s;
    s = (CNT_W+6)'(a) + (CNT_W+6)'(b);
    if (s > (CNT_W+6)'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [1:0]       sel_q, sel_d;
  logic [30:0]      gen_q, gen_d;
  logic [W-1:0]     tx_q, tx_d;
  logic             pend_q, pend_d;
  logic [30:0]      chk_q, chk_d;
  chk_state_e       state_q, state_d;
  logic [5:0]       hunt_q, hunt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic [W-1:0]     err_q, err_d;
  logic [ERR_W-1:0] tot_q, tot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             sel_chg;
  logic [30:0]      gen_seed, gen_next, chk_next;
  logic [W-1:0]     gen_bits, chk_bits, mism;

  assign sel_chg  = (prbs_sel != sel_q);
  // A new polynomial starts from the all-ones seed on the very same edge.
  assign gen_seed = sel_chg ? '1 : gen_q;

  bert_lfsr_step #(.W(W)) u_gen (
    .state_i   (gen_seed),
    .sel_i     (prbs_sel),
    .use_ext_i (1'b0),
    .ext_i     ('0),
    .state_o   (gen_next),
    .bits_o    (gen_bits)
  );

  // HUNT and VERIFY reload from the line; only LOCKED free-runs.
  bert_lfsr_step #(.W(W)) u_chk (
    .state_i   (chk_q),
    .sel_i     (sel_q),
    .use_ext_i (state_q != ST_LOCKED),
    .ext_i     (rx_data),
    .state_o   (chk_next),
    .bits_o    (chk_bits)
  );

  assign mism = chk_bits ^ rx_data;

  always_comb begin
    sel_d  = prbs_sel;
    gen_d  = gen_seed;
    tx_d   = tx_q;
    pend_d = pend_q | inject;
    if (en) begin
      gen_d  = gen_next;
      tx_d   = gen_bits ^ W'(pend_q | inject);
      pend_d = 1'b0;
    end
  end

  always_comb begin : chk_fsm
    logic [WIN_W-1:0] win_n;
    logic [BAD_W-1:0] bad_n;
    logic             upd;
    chk_d   = chk_q;
    state_d = state_q;
    hunt_d  = hunt_q;
    run_d   = run_q;
    win_d   = win_q;
    bad_d   = bad_q;
    err_d   = '0;
    tot_d   = tot_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    win_n   = win_q + 1'b1;
    bad_n   = bad_q + BAD_W'(|mism);
    upd     = 1'b0;

    if (sel_chg) begin
      // The word arriving with a polynomial change is discarded.
      state_d = ST_HUNT;
      hunt_d  = '0;
    end else if (rx_valid) begin
      chk_d = chk_next;
      case (state_q)
        ST_HUNT: begin
          if (hunt_q == fill_words(sel_q, W) - 6'd1) begin
            state_d = ST_VERIFY;
            hunt_d  = '0;
            run_d   = '0;
          end else begin
            hunt_d = hunt_q + 6'd1;
          end
        end
        ST_VERIFY: begin
          if (mism != '0) begin
            state_d = ST_HUNT;
            hunt_d  = '0;
          end else if (run_q == RUN_W'(SYNC_LEN - 1)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            bad_d   = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          err_d = mism;
          upd   = 1'b1;
          if (bad_n == BAD_W'(LOSS_THR)) begin
            state_d = ST_HUNT;
            hunt_d  = '0;
          end else if (win_n == WIN_W'(LOSS_WIN)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_n;
            bad_d = bad_n;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (clear) begin
      tot_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (upd) begin
      tot_d = sat_add_err(tot_q, popcount(32'(mism)));
      cnt_d = sat_add_cnt(cnt_q, 6'(W));
      sat_d = sat_q | (&tot_d) | (&cnt_d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Loading the live select avoids a spurious reseed on release.
      sel_q   <= prbs_sel;
      gen_q   <= '1;
      tx_q    <= '0;
      pend_q  <= 1'b0;
      chk_q   <= '1;
      state_q <= ST_HUNT;
      hunt_q  <= '0;
      run_q   <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      err_q   <= '0;
      tot_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      gen_q   <= gen_d;
      tx_q    <= tx_d;
      pend_q  <= pend_d;
      chk_q   <= chk_d;
      state_q <= state_d;
      hunt_q  <= hunt_d;
      run_q   <= run_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      tot_q   <= tot_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign tx_data     = tx_q;
  assign locked      = (state_q == ST_LOCKED);
  assign error       = err_q;
  assign total_error = tot_q;
  assign count       = cnt_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_bert_engine.sv
// tb_bert_engine: loopback bench for bert_engine (W=8). A second instance
// with a 4-bit error counter shares the stimulus for the saturation case.
module tb_bert_engine;

  logic        clk = 1'b0;
  logic        rst, en, inject, clear, rx_valid;
  logic [1:0]  prbs_sel;
  logic [7:0]  corrupt;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data, tx_data4, error, error4;
  logic        locked, locked4, sat, sat4;
  logic [15:0] total_error;
  logic [3:0]  total_error4;
  logic [31:0] count, count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rx_data = tx_data ^ corrupt;

  bert_engine #(.W(8), .CNT_W(32), .ERR_W(16), .SYNC_LEN(4), .LOSS_THR(4), .LOSS_WIN(64)) dut (
    .clock(clk), .reset(rst), .en(en), .prbs_sel(prbs_sel), .inject(inject), .clear(clear),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .locked(locked),
    .error(error), .total_error(total_error), .count(count), .sat(sat));

  bert_engine #(.W(8), .CNT_W(32), .ERR_W(4), .SYNC_LEN(4), .LOSS_THR(4), .LOSS_WIN(64)) dut4 (
    .clock(clk), .reset(rst), .en(en), .prbs_sel(prbs_sel), .inject(inject), .clear(clear),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data4), .locked(locked4),
    .error(error4), .total_error(total_error4), .count(count4), .sat(sat4));

  typedef struct {
    logic [7:0] tx;
    logic [7:0] err;
  } sb_t;
  sb_t sbq[$];

  // Expected state
  bit          exp_locked;
  int          exp_total, exp_total4;
  longint      exp_count;
  bit          exp_sat, exp_sat4;
  bit          inj_prev;
  logic [1:0]  prev_sel;

  // Reference PRBS: b[n] = b[n-N] ^ b[n-T], hist[0] newest
  bit hist[$];
  int m_n, m_t;

  task automatic model_seed(input logic [1:0] sel);
    case (sel)
      2'b00:   begin m_n = 7;  m_t = 6;  end
      2'b01:   begin m_n = 15; m_t = 14; end
      2'b10:   begin m_n = 23; m_t = 18; end
      default: begin m_n = 31; m_t = 28; end
    endcase
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
  endtask

  task automatic model_next(output logic [7:0] w);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      b = hist[m_n-1] ^ hist[m_t-1];
      w[i] = b;
      hist.push_front(b);
      void'(hist.pop_back());
    end
  endtask

  task automatic bench_init();
    exp_locked = 0; exp_total = 0; exp_total4 = 0; exp_count = 0;
    exp_sat = 0; exp_sat4 = 0; inj_prev = 0;
    prev_sel = prbs_sel;
    model_seed(prbs_sel);
    sbq.delete();
  endtask

  // One word: push expectations, clock, pop and compare.
  task automatic cycle(input logic [7:0] cm, input logic inj);
    sb_t e, g;
    bit  sel_chg, counted;
    corrupt = cm;
    inject  = inj;
    sel_chg = (prbs_sel !== prev_sel);
    if (sel_chg) begin
      model_seed(prbs_sel);
      prev_sel = prbs_sel;
    end
    model_next(e.tx);
    e.tx[0] = e.tx[0] ^ inj;
    counted = exp_locked && rx_valid && !sel_chg;
    e.err = counted ? (cm ^ {7'b0, inj_prev}) : 8'h00;
    if (clear) begin
      exp_total = 0; exp_total4 = 0; exp_count = 0; exp_sat = 0; exp_sat4 = 0;
    end else if (counted) begin
      exp_total  = exp_total + $countones(e.err);
      if (exp_total > 65535) exp_total = 65535;
      exp_total4 = exp_total4 + $countones(e.err);
      if (exp_total4 > 15) exp_total4 = 15;
      exp_count  = exp_count + 8;
      if (exp_total == 65535) exp_sat = 1;
      if (exp_total4 == 15) exp_sat4 = 1;
    end
    inj_prev = inj;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    corrupt = 8'h00;
    inject  = 1'b0;
    g = sbq.pop_front();
    checks++; if (tx_data !== g.tx) begin errors++; $display("FAIL tx_data got %h want %h", tx_data, g.tx); end
    checks++; if (tx_data4 !== g.tx) begin errors++; $display("FAIL tx_data4 got %h want %h", tx_data4, g.tx); end
    checks++; if (error !== g.err) begin errors++; $display("FAIL error got %h want %h", error, g.err); end
    checks++; if (error4 !== g.err) begin errors++; $display("FAIL error4 got %h want %h", error4, g.err); end
    checks++; if (total_error !== 16'(exp_total)) begin errors++; $display("FAIL total_error got %0d want %0d", total_error, exp_total); end
    checks++; if (total_error4 !== 4'(exp_total4)) begin errors++; $display("FAIL total_error4 got %0d want %0d", total_error4, exp_total4); end
    checks++; if (count !== 32'(exp_count)) begin errors++; $display("FAIL count got %0d want %0d", count, exp_count); end
    checks++; if (sat !== exp_sat) begin errors++; $display("FAIL sat got %b want %b", sat, exp_sat); end
    checks++; if (sat4 !== exp_sat4) begin errors++; $display("FAIL sat4 got %b want %b", sat4, exp_sat4); end
  endtask

  task automatic wait_lock(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      cycle(8'h00, 1'b0);
      checks++;
      if (locked !== (i == n)) begin
        errors++;
        $display("FAIL %s lock word %0d locked got %b want %b", tag, i, locked, (i == n));
      end
    end
    exp_locked = 1;
  endtask

  // Just out of reset: first en cycle has no valid word yet.
  task automatic lock_sequence(input string tag);
    en = 1; rx_valid = 0;
    cycle(8'h00, 1'b0);
    checks++; if (tx_data !== 8'h02) begin errors++; $display("FAIL %s first_word got %h want 02", tag, tx_data); end
    rx_valid = 1;
    wait_lock(5, tag);
  endtask

  task automatic reset_dut();
    rst = 1; en = 0; rx_valid = 0; inject = 0; clear = 0; corrupt = 0; prbs_sel = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    bench_init();
  endtask

  task automatic test_reset();
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx got %h want 00", tx_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
    checks++; if (error !== 8'h00) begin errors++; $display("FAIL rst_error got %h want 00", error); end
    checks++; if (total_error !== 16'h0) begin errors++; $display("FAIL rst_total got %0d want 0", total_error); end
    checks++; if (count !== 32'h0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (sat !== 1'b0 || sat4 !== 1'b0) begin errors++; $display("FAIL rst_sat got %b%b want 00", sat, sat4); end
  endtask

  task automatic test_lock();
    lock_sequence("lock");
    repeat (10) cycle(8'h00, 1'b0);
    checks++; if (count !== 32'd80) begin errors++; $display("FAIL lock_count got %0d want 80", count); end
  endtask

  task automatic test_loss();
    repeat (3) cycle(8'h00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(8'hFF, 1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early bad %0d locked got %b want 1", i, locked); end
    end
    cycle(8'hFF, 1'b0);
    exp_locked = 0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop locked got %b want 0", locked); end
    checks++; if (total_error !== 16'd32) begin errors++; $display("FAIL loss_total got %0d want 32", total_error); end
    wait_lock(5, "relock_after_loss");
  endtask

  task automatic test_inject();
    clear = 1;
    cycle(8'h00, 1'b0);
    clear = 0;
    checks++; if (total_error !== 16'd0 || count !== 32'd0) begin errors++; $display("FAIL clear_cnt got %0d/%0d want 0/0", total_error, count); end
    cycle(8'h00, 1'b1);
    checks++; if (error !== 8'h00) begin errors++; $display("FAIL inj_pre error got %h want 00", error); end
    cycle(8'h00, 1'b0);
    checks++; if (error !== 8'h01) begin errors++; $display("FAIL inj_error got %h want 01", error); end
    checks++; if (total_error !== 16'd1) begin errors++; $display("FAIL inj_total got %0d want 1", total_error); end
    cycle(8'h00, 1'b0);
    checks++; if (error !== 8'h00) begin errors++; $display("FAIL inj_post error got %h want 00", error); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inj_locked got %b want 1", locked); end
  endtask

  // Injections 25 words apart: never 4 errored words in one 64-word window.
  task automatic test_saturation();
    repeat (25) cycle(8'h00, 1'b0);
    clear = 1;
    cycle(8'h00, 1'b0);
    clear = 0;
    for (int j = 0; j < 20; j++) begin
      cycle(8'h00, 1'b1);
      repeat (24) cycle(8'h00, 1'b0);
    end
    checks++; if (total_error4 !== 4'hF) begin errors++; $display("FAIL sat_total4 got %h want f", total_error4); end
    checks++; if (sat4 !== 1'b1) begin errors++; $display("FAIL sat_flag4 got %b want 1", sat4); end
    checks++; if (total_error !== 16'd20) begin errors++; $display("FAIL sat_total got %0d want 20", total_error); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", locked); end
    clear = 1;
    cycle(8'h00, 1'b0);
    clear = 0;
    checks++; if (total_error4 !== 4'h0 || count4 !== 32'd0 || sat4 !== 1'b0) begin
      errors++; $display("FAIL sat_clear got %h/%0d/%b want 0/0/0", total_error4, count4, sat4);
    end
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_clear_locked got %b want 1", locked4); end
  endtask

  task automatic test_sel_change();
    prbs_sel = 2'b11;
    cycle(8'h00, 1'b0);
    exp_locked = 0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sel_drop locked got %b want 0", locked); end
    wait_lock(8, "prbs31");
    repeat (4) cycle(8'h00, 1'b0);
  endtask

  task automatic test_reset_relock();
    rst = 1; prbs_sel = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_data !== 8'h00 || locked !== 1'b0 || error !== 8'h00) begin
      errors++; $display("FAIL midrst_out got %h/%b/%h want 00/0/00", tx_data, locked, error);
    end
    checks++; if (total_error !== 16'd0 || count !== 32'd0 || sat !== 1'b0) begin
      errors++; $display("FAIL midrst_cnt got %0d/%0d/%b want 0/0/0", total_error, count, sat);
    end
    rst = 0;
    bench_init();
    lock_sequence("relock_after_reset");
    repeat (3) cycle(8'h00, 1'b0);
    checks++; if (count !== 32'd24) begin errors++; $display("FAIL midrst_count got %0d want 24", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    test_reset();
    test_lock();
    test_loss();
    test_inject();
    test_saturation();
    test_sel_change();
    test_reset_relock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
